dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and a loader, with
// round-robin fairness, a bounded loader bus lock and one-cycle read return.
module dmem_arbiter #(
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [29:0] cpu_addr,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic        ldr_lock,
    input  logic [29:0] ldr_addr,
    input  logic [3:0]  ldr_be,
    input  logic [31:0] ldr_wdata,
    output logic        ldr_gnt,
    output logic        ldr_rvalid,
    output logic [31:0] ldr_rdata,
    output logic [29:0] d_addr,
    output logic        d_we,
    output logic [3:0]  d_be,
    output logic [31:0] d_wdata,
    input  logic [31:0] d_rdata
);

    localparam logic [0:0] ST_RR   = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;
    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    logic [0:0]  state_r;
    logic        last_ldr_r;
    logic        force_cpu_r;
    logic [7:0]  lock_cnt_r;
    logic [7:0]  lock_cnt_inc_s;
    logic        cpu_gnt_s;
    logic        ldr_gnt_s;
    logic        rd_pend_r;
    logic        rd_owner_r;
    logic [31:0] cpu_rdata_r;
    logic [31:0] ldr_rdata_r;

    assign lock_cnt_inc_s = lock_cnt_r + 8'd1;

    // Grant selection: loader owns the port while locked, otherwise round-robin
    always_comb begin
        cpu_gnt_s = 1'b0;
        ldr_gnt_s = 1'b0;
        case (state_r)
            ST_LOCK: begin
                if (ldr_req) begin
                    ldr_gnt_s = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt_s = 1'b1;
                end else begin
                    cpu_gnt_s = 1'b0;
                end
            end
            default: begin
                if (cpu_req && ldr_req) begin
                    if (force_cpu_r || last_ldr_r) begin
                        cpu_gnt_s = 1'b1;
                    end else begin
                        ldr_gnt_s = 1'b1;
                    end
                end else if (cpu_req) begin
                    cpu_gnt_s = 1'b1;
                end else if (ldr_req) begin
                    ldr_gnt_s = 1'b1;
                end else begin
                    cpu_gnt_s = 1'b0;
                end
            end
        endcase
    end

    // RAM port mux follows the granted requester; idle cycles never write
    always_comb begin
        if (ldr_gnt_s) begin
            d_addr  = ldr_addr;
            d_we    = ldr_we;
            d_be    = ldr_be;
            d_wdata = ldr_wdata;
        end else if (cpu_gnt_s) begin
            d_addr  = cpu_addr;
            d_we    = cpu_we;
            d_be    = cpu_be;
            d_wdata = cpu_wdata;
        end else begin
            d_addr  = cpu_addr;
            d_we    = 1'b0;
            d_be    = 4'b0000;
            d_wdata = cpu_wdata;
        end
    end

    assign cpu_gnt   = cpu_gnt_s;
    assign ldr_gnt   = ldr_gnt_s;
    assign cpu_stall = cpu_req & ~cpu_gnt_s;

    // Arbitration state: fairness bit, lock run length and forced CPU yield
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_RR;
            last_ldr_r  <= 1'b1;
            lock_cnt_r  <= 8'd0;
            force_cpu_r <= 1'b0;
        end else begin
            force_cpu_r <= 1'b0;
            if (cpu_gnt_s) begin
                last_ldr_r <= 1'b0;
            end else if (ldr_gnt_s) begin
                last_ldr_r <= 1'b1;
            end else begin
                last_ldr_r <= last_ldr_r;
            end
            case (state_r)
                ST_LOCK: begin
                    if (ldr_gnt_s && ldr_lock) begin
                        if (lock_cnt_inc_s == MAX_LOCK_C) begin
                            state_r     <= ST_RR;
                            lock_cnt_r  <= 8'd0;
                            force_cpu_r <= cpu_req;
                        end else begin
                            lock_cnt_r <= lock_cnt_inc_s;
                        end
                    end else begin
                        state_r    <= ST_RR;
                        lock_cnt_r <= 8'd0;
                    end
                end
                default: begin
                    if (ldr_gnt_s && ldr_lock) begin
                        // A limit of one means the opening grant already exhausts the lock
                        if (MAX_LOCK_C == 8'd1) begin
                            force_cpu_r <= cpu_req;
                        end else begin
                            state_r    <= ST_LOCK;
                            lock_cnt_r <= 8'd1;
                        end
                    end else begin
                        state_r <= ST_RR;
                    end
                end
            endcase
        end
    end

    // Read return tracking: owner tag for next-cycle data and held rdata
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_r   <= 1'b0;
            rd_owner_r  <= 1'b0;
            cpu_rdata_r <= 32'd0;
            ldr_rdata_r <= 32'd0;
        end else begin
            rd_pend_r  <= (cpu_gnt_s & ~cpu_we) | (ldr_gnt_s & ~ldr_we);
            rd_owner_r <= ldr_gnt_s;
            if (rd_pend_r && !rd_owner_r) begin
                cpu_rdata_r <= d_rdata;
            end else begin
                cpu_rdata_r <= cpu_rdata_r;
            end
            if (rd_pend_r && rd_owner_r) begin
                ldr_rdata_r <= d_rdata;
            end else begin
                ldr_rdata_r <= ldr_rdata_r;
            end
        end
    end

    assign cpu_rvalid = rd_pend_r & ~rd_owner_r;
    assign ldr_rvalid = rd_pend_r & rd_owner_r;
    assign cpu_rdata  = cpu_rvalid ? d_rdata : cpu_rdata_r;
    assign ldr_rdata  = ldr_rvalid ? d_rdata : ldr_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level
// reference model of grants, lock bursts, and read data return.
module tb_dmem_arbiter;

    localparam int MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
    logic [29:0] cpu_addr, ldr_addr;
    logic [3:0]  cpu_be, ldr_be;
    logic [31:0] cpu_wdata, ldr_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, ldr_gnt, ldr_rvalid;
    logic [31:0] cpu_rdata, ldr_rdata;
    logic [29:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata, d_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
        .ldr_be(ldr_be), .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt),
        .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata)
    );

    // Synchronous RAM: read-first, byte-enabled write, contents survive reset
    logic [31:0] ram [64];
    bit          ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else begin
            d_rdata <= ram[d_addr[5:0]];
            for (int b = 0; b < 4; b++)
                if (d_we && d_be[b]) ram[d_addr[5:0]][8*b +: 8] <= d_wdata[8*b +: 8];
        end
    end

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h0000_1234;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: who won last, length of the current locked run, pending yield
    logic [31:0] refmem [64];
    int          m_last;      // 1 = loader won most recently
    int          m_lock_run;  // consecutive locked loader grants, 0 = not locked
    bit          m_yield;
    int          m_gnt;       // 0 none, 1 cpu, 2 loader
    bit          m_rv_cpu, m_rv_ldr;
    logic [31:0] m_rv_data, m_cpu_rdata, m_ldr_rdata;

    task automatic model_reset();
        m_last = 1; m_lock_run = 0; m_yield = 1'b0; m_gnt = 0;
        m_rv_cpu = 1'b0; m_rv_ldr = 1'b0;
        m_rv_data = 32'd0; m_cpu_rdata = 32'd0; m_ldr_rdata = 32'd0;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [29:0] ca,
                         input logic [3:0] cb, input logic [31:0] cd,
                         input logic lr, input logic lw, input logic ll,
                         input logic [29:0] la, input logic [3:0] lb, input logic [31:0] ld);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_be = cb; cpu_wdata = cd;
        ldr_req = lr; ldr_we = lw; ldr_lock = ll; ldr_addr = la; ldr_be = lb; ldr_wdata = ld;
    endtask

    task automatic model_check();
        #1;
        if (m_lock_run > 0 && ldr_req)  m_gnt = 2;
        else if (cpu_req && ldr_req)    m_gnt = (m_yield || m_last == 1) ? 1 : 2;
        else if (cpu_req)               m_gnt = 1;
        else if (ldr_req)               m_gnt = 2;
        else                            m_gnt = 0;
        check_val("cpu_gnt", cpu_gnt, m_gnt == 1);
        check_val("ldr_gnt", ldr_gnt, m_gnt == 2);
        check_val("cpu_stall", cpu_stall, cpu_req && m_gnt != 1);
        check_val("d_we", d_we, m_gnt == 1 ? cpu_we : (m_gnt == 2 ? ldr_we : 1'b0));
        check_val("d_be", d_be, m_gnt == 1 ? cpu_be : (m_gnt == 2 ? ldr_be : 4'b0000));
        if (m_gnt != 0) begin
            check_val("d_addr", d_addr, m_gnt == 1 ? cpu_addr : ldr_addr);
            check_val("d_wdata", d_wdata, m_gnt == 1 ? cpu_wdata : ldr_wdata);
        end
        check_val("cpu_rvalid", cpu_rvalid, m_rv_cpu);
        check_val("ldr_rvalid", ldr_rvalid, m_rv_ldr);
        check_val("cpu_rdata", cpu_rdata, m_rv_cpu ? m_rv_data : m_cpu_rdata);
        check_val("ldr_rdata", ldr_rdata, m_rv_ldr ? m_rv_data : m_ldr_rdata);
    endtask

    task automatic advance();
        logic [29:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          we;
        bit          yield_next;
        if (m_rv_cpu) m_cpu_rdata = m_rv_data;
        if (m_rv_ldr) m_ldr_rdata = m_rv_data;
        a  = (m_gnt == 2) ? ldr_addr : cpu_addr;
        be = (m_gnt == 2) ? ldr_be : cpu_be;
        wd = (m_gnt == 2) ? ldr_wdata : cpu_wdata;
        we = (m_gnt == 2) ? ldr_we : cpu_we;
        m_rv_cpu = (m_gnt == 1) && !we;
        m_rv_ldr = (m_gnt == 2) && !we;
        if (m_gnt != 0 && !we) m_rv_data = refmem[a[5:0]];
        if (m_gnt != 0 && we)
            for (int b = 0; b < 4; b++)
                if (be[b]) refmem[a[5:0]][8*b +: 8] = wd[8*b +: 8];
        yield_next = 1'b0;
        if (m_gnt == 2) begin
            m_last = 1;
            if (ldr_lock) begin
                m_lock_run++;
                if (m_lock_run == MAX_LOCK) begin
                    m_lock_run = 0;
                    yield_next = cpu_req;
                end
            end else begin
                m_lock_run = 0;
            end
        end else begin
            if (m_gnt == 1) m_last = 0;
            m_lock_run = 0;
        end
        m_yield = yield_next;
        @(posedge clk);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive(1'b0, 1'b0, 30'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        model_check();
        advance();
    endtask

    initial begin
        bit          prev_cpu;
        logic [29:0] ca, la;
        for (int i = 0; i < 64; i++) refmem[i] = init_word(i);
        model_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 30'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check_val("rst_ldr_rvalid", ldr_rvalid, 1'b0);
        check_val("rst_cpu_rdata", cpu_rdata, 32'd0);
        check_val("rst_ldr_rdata", ldr_rdata, 32'd0);
        check_val("rst_d_we", d_we, 1'b0);
        check_val("rst_d_be", d_be, 4'b0000);
        cpu_req = 1'b1;
        #1;
        check_val("rst_gnt_ungated", cpu_gnt, 1'b1);
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // First conflict after reset goes to the CPU, then the loader
        drive(1'b1, 1'b0, 30'h10, 4'hF, 32'd0, 1'b1, 1'b0, 1'b0, 30'h20, 4'hF, 32'd0);
        model_check();
        check_val("c0_cpu_gnt", cpu_gnt, 1'b1);
        check_val("c0_d_addr", d_addr, 30'h10);
        advance();
        @(negedge clk);
        drive(1'b0, 1'b0, 30'h10, 4'hF, 32'd0, 1'b1, 1'b0, 1'b0, 30'h20, 4'hF, 32'd0);
        model_check();
        check_val("c1_ldr_gnt", ldr_gnt, 1'b1);
        check_val("c1_d_addr", d_addr, 30'h20);
        check_val("c1_cpu_rvalid", cpu_rvalid, 1'b1);
        check_val("c1_cpu_rdata", cpu_rdata, init_word(16));
        advance();
        @(negedge clk);
        drive(1'b0, 1'b0, 30'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        model_check();
        check_val("c2_ldr_rvalid", ldr_rvalid, 1'b1);
        check_val("c2_ldr_rdata", ldr_rdata, init_word(32));
        advance();

        // CPU partial write alone
        @(negedge clk);
        drive(1'b1, 1'b1, 30'd3, 4'b0011, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        model_check();
        check_val("wr_d_we", d_we, 1'b1);
        check_val("wr_d_be", d_be, 4'b0011);
        check_val("wr_d_wdata", d_wdata, 32'hDEADBEEF);
        advance();
        @(negedge clk);
        drive(1'b0, 1'b0, 30'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        model_check();
        check_val("wr_no_cpu_rvalid", cpu_rvalid, 1'b0);
        check_val("wr_no_ldr_rvalid", ldr_rvalid, 1'b0);
        advance();

        // Locked loader burst against a waiting CPU: MAX_LOCK grants, then forced yield
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 30'd7, 4'hF, 32'd0,
                  1'b1, 1'b1, 1'b1, 30'(40 + i), 4'hF, 32'(i + 100));
            model_check();
            check_val("lock_ldr_gnt", ldr_gnt, i < MAX_LOCK);
            check_val("lock_cpu_gnt", cpu_gnt, i == MAX_LOCK);
            check_val("lock_cpu_stall", cpu_stall, i < MAX_LOCK);
            advance();
        end
        idle_cycle();

        // Alternating conflicting reads
        ca = 30'd1; la = 30'd33;
        prev_cpu = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, ca, 4'hF, 32'd0, 1'b1, 1'b0, 1'b0, la, 4'hF, 32'd0);
            model_check();
            check_val("alt_toggle", cpu_gnt, !prev_cpu);
            prev_cpu = cpu_gnt;
            if (m_gnt == 1) ca = ca + 30'd1;
            if (m_gnt == 2) la = la + 30'd1;
            advance();
        end
        idle_cycle();

        // Reset right after a granted CPU read discards the return
        @(negedge clk);
        drive(1'b1, 1'b0, 30'd9, 4'hF, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        model_check();
        advance();
        @(negedge clk);
        drive(1'b0, 1'b0, 30'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0, 4'd0, 32'd0);
        reset = 1'b1;
        #1;
        check_val("rstmid_cpu_rvalid", cpu_rvalid, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 30'd11, 4'hF, 32'd0, 1'b1, 1'b0, 1'b0, 30'd12, 4'hF, 32'd0);
        model_check();
        check_val("rstmid_cpu_wins", cpu_gnt, 1'b1);
        advance();

        // Random traffic; requests hold their fields until granted or dropped
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (cpu_req && m_gnt != 1) begin
                if ($urandom_range(0, 15) == 0) cpu_req = 1'b0;
            end else begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 30'($urandom_range(0, 63));
                cpu_be    = 4'($urandom);
                cpu_wdata = $urandom;
            end
            if (ldr_req && m_gnt != 2) begin
                if ($urandom_range(0, 15) == 0) ldr_req = 1'b0;
            end else begin
                ldr_req   = ($urandom_range(0, 3) != 0);
                ldr_we    = 1'($urandom_range(0, 1));
                ldr_addr  = 30'($urandom_range(0, 63));
                ldr_be    = 4'($urandom);
                ldr_wdata = $urandom;
            end
            ldr_lock = ($urandom_range(0, 3) != 0);
            model_check();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
